// File: rtl/p_hardisc.sv
// Shared types and defaults for the operand-preparation stage.
package p_hardisc;

  typedef logic [4:0] rf_add;

  typedef enum logic [1:0] {
    IMM_NONE  = 2'b00,
    IMM_SEXT  = 2'b01,
    IMM_UPPER = 2'b10,
    IMM_ZEXT  = 2'b11
  } imsel_t;

  localparam int unsigned MAX_PEND_DEF = 4;

endpackage

// File: rtl/op_scoreboard.sv
// Pending-write scoreboard for long-latency writers: bitmap, occupancy
// counter, and per-operand / WAW / capacity hazard detection with retire bypass.
module op_scoreboard
  import p_hardisc::*;
#(
  parameter int unsigned NUM_RP   = 2,
  parameter int unsigned MAX_PEND = MAX_PEND_DEF
) (
  input  logic                s_clk_i,
  input  logic                s_reset_i,
  input  logic                s_set_i,
  input  logic                s_clr_i,
  input  logic [4:0]          s_clr_rd_i,
  input  logic [NUM_RP*5-1:0] s_rs_i,
  input  logic [NUM_RP-1:0]   s_rfrp_i,
  input  logic [4:0]          s_rd_i,
  input  logic                s_long_i,
  output logic [31:0]         s_pend_o,
  output logic [NUM_RP-1:0]   s_rs_haz_o,
  output logic                s_waw_o,
  output logic                s_cap_o
);

  localparam int unsigned CNT_W = $clog2(MAX_PEND + 1);

  logic [31:0]      pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear is applied before set so a same-register set/clear leaves the bit set.
  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (s_clr_i) pend_d[s_clr_rd_i] = 1'b0;
    if (s_set_i) pend_d[s_rd_i] = 1'b1;
    pend_d[0] = 1'b0;
    if (s_set_i && !s_clr_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!s_set_i && s_clr_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // A writeback to the same register this cycle releases the dependent early.
  always_comb begin
    rf_add rs;
    s_rs_haz_o = '0;
    rs         = '0;
    for (int unsigned k = 0; k < NUM_RP; k++) begin
      rs = s_rs_i[k*5 +: 5];
      s_rs_haz_o[k] = s_rfrp_i[k] & pend_q[rs] & ~(s_clr_i & (s_clr_rd_i == rs));
    end
  end

  assign s_waw_o  = (s_rd_i != '0) & pend_q[s_rd_i];
  assign s_cap_o  = s_long_i & (cnt_q == CNT_W'(MAX_PEND)) & ~s_clr_i;
  assign s_pend_o = pend_q;

endmodule

// File: rtl/operand_stage_sb.sv
// Operand-preparation stage: forwarding mux, immediate expansion, scoreboard
// stalls, registered valid/ready output. Optional RF error flags: OPS_RF_ERR_EN.
module operand_stage_sb
  import p_hardisc::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_RP   = 2,
  parameter int unsigned NUM_FWD  = 3,
  parameter int unsigned MAX_PEND = MAX_PEND_DEF
) (
  input  logic                   s_clk_i,
  input  logic                   s_reset_i,
  input  logic                   s_flush_i,
  input  logic                   s_id_valid_i,
  output logic                   s_id_ready_o,
  input  logic [NUM_RP*5-1:0]    s_id_rs_i,
  input  logic [NUM_RP-1:0]      s_id_rfrp_i,
  input  logic [NUM_RP-1:0]      s_id_zero_i,
  input  logic [4:0]             s_id_rd_i,
  input  logic                   s_id_long_i,
  input  logic [19:0]            s_id_imm_i,
  input  logic [1:0]             s_id_imsel_i,
  input  logic [NUM_RP*XLEN-1:0] s_rf_val_i,
  input  logic [NUM_FWD*5-1:0]   s_fwd_rd_i,
  input  logic [NUM_FWD-1:0]     s_fwd_wr_i,
  input  logic [NUM_FWD-1:0]     s_fwd_avl_i,
  input  logic [NUM_FWD*XLEN-1:0] s_fwd_val_i,
  input  logic                   s_lret_i,
  input  logic [4:0]             s_lret_rd_i,
  output logic                   s_ex_valid_o,
  input  logic                   s_ex_ready_i,
  output logic [NUM_RP*XLEN-1:0] s_ex_op_o,
  output logic [XLEN-1:0]        s_ex_imm_o,
  output logic [4:0]             s_ex_rd_o,
`ifdef OPS_RF_ERR_EN
  input  logic [NUM_RP-1:0]      s_rf_uce_i,
  input  logic [NUM_RP-1:0]      s_rf_ce_i,
  output logic                   s_uce_o,
  output logic                   s_ce_o,
`endif
  output logic [31:0]            s_pend_o,
  output logic                   s_stall_o
);

  logic [NUM_RP*5-1:0]    rs_eff;
  logic [NUM_RP-1:0]      fwd_haz;
  logic [NUM_RP-1:0]      from_rf;
  logic [NUM_RP-1:0]      sb_rs_haz;
  logic                   sb_waw, sb_cap, sb_set;
  logic                   hazard, id_ready;
  logic [XLEN-1:0]        imm_x;

  logic                   ex_valid_q, ex_valid_d;
  logic [NUM_RP*XLEN-1:0] ex_op_q, ex_op_d, op_sel;
  logic [XLEN-1:0]        ex_imm_q, ex_imm_d;
  logic [4:0]             ex_rd_q, ex_rd_d;

  for (genvar k = 0; k < NUM_RP; k++) begin : g_opnd
    logic            hit, haz;
    logic [XLEN-1:0] val;

    assign rs_eff[k*5 +: 5] = s_id_zero_i[k] ? 5'd0 : s_id_rs_i[k*5 +: 5];

    // Ascending scan with a found flag: the youngest matching source wins.
    always_comb begin
      hit = 1'b0;
      haz = 1'b0;
      val = s_rf_val_i[k*XLEN +: XLEN];
      for (int unsigned j = 0; j < NUM_FWD; j++) begin
        if (!hit && s_id_rfrp_i[k] && s_fwd_wr_i[j] && (rs_eff[k*5 +: 5] != 5'd0) &&
            (s_fwd_rd_i[j*5 +: 5] == rs_eff[k*5 +: 5])) begin
          hit = 1'b1;
          if (s_fwd_avl_i[j]) val = s_fwd_val_i[j*XLEN +: XLEN];
          else                haz = 1'b1;
        end
      end
      if (s_id_zero_i[k]) val = '0;
    end

    assign fwd_haz[k]               = haz;
    assign from_rf[k]               = s_id_rfrp_i[k] & ~s_id_zero_i[k] & ~hit;
    assign op_sel[k*XLEN +: XLEN]   = val;
  end

  op_scoreboard #(
    .NUM_RP   (NUM_RP),
    .MAX_PEND (MAX_PEND)
  ) u_sb (
    .s_clk_i    (s_clk_i),
    .s_reset_i  (s_reset_i),
    .s_set_i    (sb_set),
    .s_clr_i    (s_lret_i),
    .s_clr_rd_i (s_lret_rd_i),
    .s_rs_i     (rs_eff),
    .s_rfrp_i   (s_id_rfrp_i),
    .s_rd_i     (s_id_rd_i),
    .s_long_i   (s_id_long_i),
    .s_pend_o   (s_pend_o),
    .s_rs_haz_o (sb_rs_haz),
    .s_waw_o    (sb_waw),
    .s_cap_o    (sb_cap)
  );

  assign hazard = (|fwd_haz) | (|sb_rs_haz) | sb_waw | sb_cap;

`ifdef OPS_RF_ERR_EN
  logic uce_any, ce_any;
  logic uce_q, uce_d, ce_q, ce_d;
  assign uce_any   = |(s_rf_uce_i & from_rf);
  assign ce_any    = |(s_rf_ce_i & from_rf) & ~uce_any;
  // An uncorrectable error lets the instruction through to be trapped downstream.
  assign s_stall_o = s_id_valid_i & hazard & ~uce_any;
`else
  logic unused_from_rf;
  assign unused_from_rf = |from_rf;
  assign s_stall_o = s_id_valid_i & hazard;
`endif

  assign id_ready     = s_id_valid_i & ~s_stall_o & ~s_flush_i & (~ex_valid_q | s_ex_ready_i);
  assign s_id_ready_o = id_ready;
  assign sb_set       = id_ready & s_id_long_i & (s_id_rd_i != 5'd0);

  always_comb begin
    imm_x = '0;
    case (imsel_t'(s_id_imsel_i))
      IMM_SEXT: begin
        imm_x       = {XLEN{s_id_imm_i[19]}};
        imm_x[19:0] = s_id_imm_i;
      end
      IMM_UPPER: imm_x[31:12] = s_id_imm_i;
      IMM_ZEXT:  imm_x[19:0]  = s_id_imm_i;
      default:   imm_x        = '0;
    endcase
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_op_d    = ex_op_q;
    ex_imm_d   = ex_imm_q;
    ex_rd_d    = ex_rd_q;
    if (id_ready) begin
      ex_valid_d = 1'b1;
      ex_op_d    = op_sel;
      ex_imm_d   = imm_x;
      ex_rd_d    = s_id_rd_i;
    end else if (s_flush_i || s_ex_ready_i) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_imm_q   <= '0;
      ex_rd_q    <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_imm_q   <= ex_imm_d;
      ex_rd_q    <= ex_rd_d;
    end
  end

`ifdef OPS_RF_ERR_EN
  always_comb begin
    uce_d = uce_q;
    ce_d  = ce_q;
    if (id_ready) begin
      uce_d = uce_any;
      ce_d  = ce_any;
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      uce_q <= 1'b0;
      ce_q  <= 1'b0;
    end else begin
      uce_q <= uce_d;
      ce_q  <= ce_d;
    end
  end

  assign s_uce_o = uce_q;
  assign s_ce_o  = ce_q;
`endif

  assign s_ex_valid_o = ex_valid_q;
  assign s_ex_op_o    = ex_op_q;
  assign s_ex_imm_o   = ex_imm_q;
  assign s_ex_rd_o    = ex_rd_q;

endmodule

// File: tb/tb_operand_stage_sb.sv
// Directed bench for operand_stage_sb with a per-cycle reference model.
module tb_operand_stage_sb;

  localparam int XLEN = 32, NUM_RP = 2, NUM_FWD = 3, MAX_PEND = 4;

  logic clk;
  logic s_reset_i, s_flush_i, s_id_valid_i, s_id_ready_o;
  logic [NUM_RP*5-1:0] s_id_rs_i;
  logic [NUM_RP-1:0] s_id_rfrp_i, s_id_zero_i;
  logic [4:0] s_id_rd_i;
  logic s_id_long_i;
  logic [19:0] s_id_imm_i;
  logic [1:0] s_id_imsel_i;
  logic [NUM_RP*XLEN-1:0] s_rf_val_i;
  logic [NUM_FWD*5-1:0] s_fwd_rd_i;
  logic [NUM_FWD-1:0] s_fwd_wr_i, s_fwd_avl_i;
  logic [NUM_FWD*XLEN-1:0] s_fwd_val_i;
  logic s_lret_i;
  logic [4:0] s_lret_rd_i;
  logic s_ex_valid_o, s_ex_ready_i;
  logic [NUM_RP*XLEN-1:0] s_ex_op_o;
  logic [XLEN-1:0] s_ex_imm_o;
  logic [4:0] s_ex_rd_o;
  logic [31:0] s_pend_o;
  logic s_stall_o;
`ifdef OPS_RF_ERR_EN
  logic s_uce_o, s_ce_o;
`endif

  operand_stage_sb #(.XLEN(XLEN), .NUM_RP(NUM_RP), .NUM_FWD(NUM_FWD), .MAX_PEND(MAX_PEND)) dut (
    .s_clk_i(clk), .s_reset_i(s_reset_i), .s_flush_i(s_flush_i),
    .s_id_valid_i(s_id_valid_i), .s_id_ready_o(s_id_ready_o),
    .s_id_rs_i(s_id_rs_i), .s_id_rfrp_i(s_id_rfrp_i), .s_id_zero_i(s_id_zero_i),
    .s_id_rd_i(s_id_rd_i), .s_id_long_i(s_id_long_i), .s_id_imm_i(s_id_imm_i),
    .s_id_imsel_i(s_id_imsel_i), .s_rf_val_i(s_rf_val_i),
    .s_fwd_rd_i(s_fwd_rd_i), .s_fwd_wr_i(s_fwd_wr_i), .s_fwd_avl_i(s_fwd_avl_i),
    .s_fwd_val_i(s_fwd_val_i), .s_lret_i(s_lret_i), .s_lret_rd_i(s_lret_rd_i),
    .s_ex_valid_o(s_ex_valid_o), .s_ex_ready_i(s_ex_ready_i),
    .s_ex_op_o(s_ex_op_o), .s_ex_imm_o(s_ex_imm_o), .s_ex_rd_o(s_ex_rd_o),
`ifdef OPS_RF_ERR_EN
    .s_rf_uce_i('0), .s_rf_ce_i('0), .s_uce_o(s_uce_o), .s_ce_o(s_ce_o),
`endif
    .s_pend_o(s_pend_o), .s_stall_o(s_stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: architectural view of pending registers, occupancy and output slot.
  bit [31:0] m_pend;
  int m_cnt;
  bit m_v, m_live, m_set;
  logic [NUM_RP*XLEN-1:0] m_op, e_op;
  logic [XLEN-1:0] m_imm, e_imm, v_m;
  logic [4:0] m_rd;
  bit e_haz, e_stall, e_ready, found_m;
  int rs_m;

  always begin
    @(negedge clk);
    e_haz = 1'b0;
    for (int k = 0; k < NUM_RP; k++) begin
      rs_m = s_id_zero_i[k] ? 0 : int'(s_id_rs_i[k*5 +: 5]);
      v_m = s_rf_val_i[k*XLEN +: XLEN];
      found_m = 1'b0;
      if (s_id_rfrp_i[k] && rs_m != 0)
        for (int j = 0; j < NUM_FWD; j++)
          if (!found_m && s_fwd_wr_i[j] && int'(s_fwd_rd_i[j*5 +: 5]) == rs_m) begin
            found_m = 1'b1;
            if (s_fwd_avl_i[j]) v_m = s_fwd_val_i[j*XLEN +: XLEN];
            else e_haz = 1'b1;
          end
      if (s_id_zero_i[k]) v_m = '0;
      if (s_id_rfrp_i[k] && m_pend[rs_m] && !(s_lret_i && int'(s_lret_rd_i) == rs_m)) e_haz = 1'b1;
      e_op[k*XLEN +: XLEN] = v_m;
    end
    if (s_id_rd_i != 5'd0 && m_pend[s_id_rd_i]) e_haz = 1'b1;
    if (s_id_long_i && m_cnt == MAX_PEND && !s_lret_i) e_haz = 1'b1;
    e_stall = s_id_valid_i && e_haz;
    e_ready = s_id_valid_i && !e_haz && !s_flush_i && (!m_v || s_ex_ready_i);
    case (s_id_imsel_i)
      2'b01:   e_imm = {{12{s_id_imm_i[19]}}, s_id_imm_i};
      2'b10:   e_imm = {s_id_imm_i, 12'h000};
      2'b11:   e_imm = {12'h000, s_id_imm_i};
      default: e_imm = '0;
    endcase
    if (m_live) begin
      chk("mdl_ready", 64'(s_id_ready_o), 64'(e_ready));
      chk("mdl_stall", 64'(s_stall_o), 64'(e_stall));
      chk("mdl_valid", 64'(s_ex_valid_o), 64'(m_v));
      chk("mdl_op", s_ex_op_o, m_op);
      chk("mdl_imm", 64'(s_ex_imm_o), 64'(m_imm));
      chk("mdl_rd", 64'(s_ex_rd_o), 64'(m_rd));
      chk("mdl_pend", 64'(s_pend_o), 64'(m_pend));
    end
    @(posedge clk);
    if (s_reset_i) begin
      m_pend = '0; m_cnt = 0; m_v = 1'b0; m_op = '0; m_imm = '0; m_rd = '0; m_live = 1'b1;
    end else begin
      m_set = e_ready && s_id_long_i && (s_id_rd_i != 5'd0);
      if (s_lret_i) m_pend[s_lret_rd_i] = 1'b0;
      if (m_set) m_pend[s_id_rd_i] = 1'b1;
      if (m_set && !s_lret_i) m_cnt++;
      else if (!m_set && s_lret_i && m_cnt > 0) m_cnt--;
      if (e_ready) begin
        m_v = 1'b1; m_op = e_op; m_imm = e_imm; m_rd = s_id_rd_i;
      end else if (s_flush_i || s_ex_ready_i) begin
        m_v = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic idle();
    s_flush_i = 0; s_id_valid_i = 0; s_id_rs_i = '0; s_id_rfrp_i = '0; s_id_zero_i = '0;
    s_id_rd_i = '0; s_id_long_i = 0; s_id_imm_i = '0; s_id_imsel_i = '0; s_rf_val_i = '0;
    s_fwd_rd_i = '0; s_fwd_wr_i = '0; s_fwd_avl_i = '0; s_fwd_val_i = '0;
    s_lret_i = 0; s_lret_rd_i = '0; s_ex_ready_i = 1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic lng);
    s_id_valid_i = 1; s_id_rd_i = rd; s_id_long_i = lng;
  endtask

  int lr[4] = '{1, 3, 4, 5};

  initial begin
    idle();
    s_reset_i = 1;
    cyc(); cyc();
    s_reset_i = 0;
    neg();
    chk("rst_valid", 64'(s_ex_valid_o), 64'd0);
    chk("rst_pend", 64'(s_pend_o), 64'd0);
    chk("rst_op", s_ex_op_o, 64'd0);
    chk("rst_ready", 64'(s_id_ready_o), 64'd0);

    // Forward priority: fwd0 and fwd2 both write x5; youngest wins.
    cyc(); idle();
    issue(5'd10, 0); s_id_rs_i = {5'd0, 5'd5}; s_id_rfrp_i = 2'b01;
    s_id_imsel_i = 2'b01; s_id_imm_i = 20'h80001;
    s_fwd_rd_i = {5'd5, 5'd9, 5'd5}; s_fwd_wr_i = 3'b101; s_fwd_avl_i = 3'b111;
    s_fwd_val_i = {32'h5555, 32'h0, 32'hAAAA}; s_rf_val_i = {32'h0, 32'h1234};
    neg();
    chk("fwd_ready", 64'(s_id_ready_o), 64'd1);
    chk("fwd_stall", 64'(s_stall_o), 64'd0);
    cyc(); idle(); neg();
    chk("fwd_valid", 64'(s_ex_valid_o), 64'd1);
    chk("fwd_op0", 64'(s_ex_op_o[31:0]), 64'h0000AAAA);
    chk("sext_imm", 64'(s_ex_imm_o), 64'hFFF80001);
    chk("fwd_rd", 64'(s_ex_rd_o), 64'd10);

    // EX value not yet available.
    cyc(); idle();
    issue(5'd11, 0); s_id_rs_i = {5'd0, 5'd5}; s_id_rfrp_i = 2'b01;
    s_fwd_rd_i = {5'd0, 5'd0, 5'd5}; s_fwd_wr_i = 3'b001; s_fwd_avl_i = 3'b000;
    s_fwd_val_i[31:0] = 32'h77;
    neg();
    chk("unavl_ready", 64'(s_id_ready_o), 64'd0);
    chk("unavl_stall", 64'(s_stall_o), 64'd1);
    cyc(); s_fwd_avl_i = 3'b001; neg();
    chk("avl_ready", 64'(s_id_ready_o), 64'd1);
    cyc(); idle(); neg();
    chk("avl_op0", 64'(s_ex_op_o[31:0]), 64'h77);

    // Long op rd=7, dependent on rs2=7 released by same-cycle writeback.
    cyc(); idle(); issue(5'd7, 1); neg();
    chk("div_ready", 64'(s_id_ready_o), 64'd1);
    cyc(); idle(); issue(5'd8, 0); s_id_rs_i = {5'd7, 5'd0}; s_id_rfrp_i = 2'b10; neg();
    chk("div_pend", 64'(s_pend_o), 64'h80);
    chk("dep_stall1", 64'(s_stall_o), 64'd1);
    cyc(); neg();
    chk("dep_stall2", 64'(s_stall_o), 64'd1);
    cyc(); s_lret_i = 1; s_lret_rd_i = 5'd7; s_rf_val_i = {32'hD1D1, 32'h0}; neg();
    chk("dep_ready", 64'(s_id_ready_o), 64'd1);
    cyc(); idle(); neg();
    chk("dep_op1", 64'(s_ex_op_o[63:32]), 64'hD1D1);
    chk("dep_pend", 64'(s_pend_o), 64'd0);

    // Capacity: four outstanding, fifth stalls until a same-cycle retire.
    for (int r = 1; r <= 4; r++) begin
      cyc(); idle(); issue(5'(r), 1); neg();
      chk("cap_fill", 64'(s_id_ready_o), 64'd1);
    end
    cyc(); idle(); issue(5'd5, 1); neg();
    chk("cap_full", 64'(s_id_ready_o), 64'd0);
    chk("cap_stall", 64'(s_stall_o), 64'd1);
    cyc(); s_lret_i = 1; s_lret_rd_i = 5'd2; neg();
    chk("cap_bypass", 64'(s_id_ready_o), 64'd1);
    cyc(); idle(); issue(5'd6, 1); neg();
    chk("cap_pend", 64'(s_pend_o), 64'h3A);
    chk("cap_still4", 64'(s_id_ready_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(); idle(); s_lret_i = 1; s_lret_rd_i = 5'(lr[i]);
    end
    cyc(); idle(); neg();
    chk("cap_drain", 64'(s_pend_o), 64'd0);

    // Backpressure holds output for 3 cycles, then flush.
    cyc(); idle(); s_ex_ready_i = 0; issue(5'd9, 1);
    s_id_imsel_i = 2'b10; s_id_imm_i = 20'hABCDE;
    s_id_rs_i = {5'd0, 5'd3}; s_id_rfrp_i = 2'b01; s_rf_val_i = {32'h0, 32'hCAFE};
    neg();
    chk("bp_accept", 64'(s_id_ready_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(); idle(); s_ex_ready_i = 0; issue(5'd12, 0); neg();
      chk("bp_valid", 64'(s_ex_valid_o), 64'd1);
      chk("bp_op0", 64'(s_ex_op_o[31:0]), 64'hCAFE);
      chk("upper_imm", 64'(s_ex_imm_o), 64'hABCDE000);
      chk("bp_rd", 64'(s_ex_rd_o), 64'd9);
      chk("bp_ready", 64'(s_id_ready_o), 64'd0);
    end
    cyc(); idle(); s_flush_i = 1; s_ex_ready_i = 0; issue(5'd12, 0); neg();
    chk("fl_ready", 64'(s_id_ready_o), 64'd0);
    cyc(); idle(); neg();
    chk("fl_valid", 64'(s_ex_valid_o), 64'd0);
    chk("fl_pend", 64'(s_pend_o), 64'h200);
    cyc(); idle(); issue(5'd13, 0); s_id_imsel_i = 2'b11; s_id_imm_i = 20'h80001;
    cyc(); idle(); neg();
    chk("zext_imm", 64'(s_ex_imm_o), 64'h00080001);
    cyc(); idle(); s_lret_i = 1; s_lret_rd_i = 5'd9;
    cyc(); idle(); neg();
    chk("fl_retire", 64'(s_pend_o), 64'd0);

    // Reset mid-operation with x4..x7 outstanding.
    for (int r = 4; r <= 7; r++) begin
      cyc(); idle(); issue(5'(r), 1);
    end
    cyc(); idle(); s_ex_ready_i = 0; s_reset_i = 1; neg();
    chk("pre_rst_pend", 64'(s_pend_o), 64'hF0);
    chk("pre_rst_valid", 64'(s_ex_valid_o), 64'd1);
    cyc(); s_reset_i = 0; idle(); neg();
    chk("mid_rst_pend", 64'(s_pend_o), 64'd0);
    chk("mid_rst_valid", 64'(s_ex_valid_o), 64'd0);
    for (int r = 1; r <= 4; r++) begin
      cyc(); idle(); issue(5'(r), 1); neg();
      chk("rst_cnt_fill", 64'(s_id_ready_o), 64'd1);
    end
    cyc(); idle(); issue(5'd5, 1); neg();
    chk("rst_cnt_full", 64'(s_id_ready_o), 64'd0);
    cyc(); idle(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
